// File: rtl/image_loader.sv
// image_loader: streams signed 8-bit pixels into a two-bank image RAM, one
// bank per frame, with per-bank full flags handed back by the consumer.
`default_nettype none

module image_loader #(
   parameter int PIXELS = 784,
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              s_valid_i,
   input  logic [7:0]        s_data_i,
   output logic              s_ready_o,
   output logic              wr_en_o,
   output logic              wr_bank_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [7:0]        wr_data_o,
   output logic              img_done_o,
   output logic              img_bank_o,
   input  logic              release_i,
   input  logic              release_bank_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              fb_q, fb_d;
   logic [1:0]        full_q, full_d;
   logic              wr_en_q, wr_en_d;
   logic              wr_bank_q, wr_bank_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              img_done_q, img_done_d;
   logic              img_bank_q, img_bank_d;
   logic              s_ready;
   logic              xfer;

   // Registered-only decode keeps s_valid out of the ready path.
   assign s_ready = (state_q == FILL) && !full_q[fb_q];
   assign xfer    = s_valid_i && s_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fb_d       = fb_q;
      full_d     = full_q;
      wr_en_d    = 1'b0;
      wr_bank_d  = wr_bank_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      img_done_d = 1'b0;
      img_bank_d = img_bank_q;

      if (release_i) begin
         full_d[release_bank_i] = 1'b0;
      end

      // A transfer always lands in RAM, even when abort arrives with it.
      if (xfer) begin
         wr_en_d   = 1'b1;
         wr_addr_d = cnt_q;
         wr_bank_d = fb_q;
         wr_data_d = s_data_i;
      end

      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         FILL: begin
            if (abort_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (xfer) begin
               if (cnt_q == LAST) begin
                  full_d[fb_q] = 1'b1;
                  img_done_d   = 1'b1;
                  img_bank_d   = fb_q;
                  cnt_d        = '0;
                  fb_d         = !fb_q;
                  // Same-cycle release of the other bank avoids the stall.
                  state_d      = full_d[!fb_q] ? STALL : FILL;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         STALL: begin
            if (abort_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (!full_q[fb_q]) begin
               state_d = FILL;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         fb_q       <= 1'b0;
         full_q     <= 2'b00;
         wr_en_q    <= 1'b0;
         wr_bank_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'd0;
         img_done_q <= 1'b0;
         img_bank_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fb_q       <= fb_d;
         full_q     <= full_d;
         wr_en_q    <= wr_en_d;
         wr_bank_q  <= wr_bank_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         img_done_q <= img_done_d;
         img_bank_q <= img_bank_d;
      end
   end

   assign s_ready_o  = s_ready;
   assign wr_en_o    = wr_en_q;
   assign wr_bank_o  = wr_bank_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign img_done_o = img_done_q;
   assign img_bank_o = img_bank_q;
   assign busy_o     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_image_loader.sv
// tb_image_loader: random and directed stimulus against a frame-level model
// of the loader; every cycle's outputs are compared with the model.
`default_nettype none

module tb_image_loader;
   localparam int PIX = 784;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0, abort = 1'b0, s_valid = 1'b0;
   logic [7:0] s_data = 8'd0;
   logic       rel = 1'b0, rel_bank = 1'b0;
   logic       s_ready, wr_en, wr_bank, img_done, img_bank, busy;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;

   image_loader #(.PIXELS(PIX), .ADDR_W(10)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
      .wr_en_o(wr_en), .wr_bank_o(wr_bank), .wr_addr_o(wr_addr),
      .wr_data_o(wr_data), .img_done_o(img_done), .img_bank_o(img_bank),
      .release_i(rel), .release_bank_i(rel_bank), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int n_wr = 0, n_done = 0;
   bit cmp_en = 1'b0;

   // Frame-level model: loading flag, waiting-for-bank flag, pixel index, bank, full flags.
   bit         m_load, m_wait, m_bank;
   bit   [1:0] m_full;
   int         m_idx;
   bit         e_wr, e_bank, e_done, e_dbank;
   int         e_addr;
   logic [7:0] e_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   function automatic bit m_ready();
      return m_load && !m_wait && !m_full[m_bank];
   endfunction

   task automatic model_reset();
      m_load = 0; m_wait = 0; m_bank = 0; m_full = 2'b00; m_idx = 0;
      e_wr = 0; e_bank = 0; e_done = 0; e_dbank = 0; e_addr = 0; e_data = 8'd0;
   endtask

   task automatic model_step(input bit st, input bit ab, input bit v, input logic [7:0] d,
                             input bit rl, input bit rb, output bit acc);
      bit [1:0] nf;
      acc    = v && m_ready();
      e_wr   = acc;
      e_done = 0;
      if (acc) begin
         e_addr = m_idx; e_bank = m_bank; e_data = d;
      end
      nf = m_full;
      if (rl) nf[rb] = 1'b0;
      if (m_load && ab) begin
         m_load = 0; m_wait = 0; m_idx = 0;
      end else if (m_load) begin
         if (m_wait && !m_full[m_bank]) m_wait = 0;
         if (acc) begin
            if (m_idx == PIX - 1) begin
               nf[m_bank] = 1'b1;
               e_done = 1; e_dbank = m_bank;
               m_idx = 0;
               m_bank = !m_bank;
               m_wait = nf[m_bank];
            end else begin
               m_idx++;
            end
         end
      end else if (st) begin
         m_load = 1; m_idx = 0; m_wait = 0;
      end
      m_full = nf;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("s_ready", s_ready, m_ready());
         chk("busy", busy, m_load);
         chk("wr_en", wr_en, e_wr);
         chk("img_done", img_done, e_done);
         if (e_wr) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_bank", wr_bank, e_bank);
            chk("wr_data", wr_data, e_data);
         end
         if (e_done) chk("img_bank", img_bank, e_dbank);
         if (wr_en) n_wr++;
         if (img_done) n_done++;
      end
   end

   task automatic cyc(input bit st, input bit ab, input bit v, input logic [7:0] d,
                      input bit rl, input bit rb, output bit acc);
      start = st; abort = ab; s_valid = v; s_data = d; rel = rl; rel_bank = rb;
      @(posedge clk);
      acc = 0;
      if (rst_n) model_step(st, ab, v, d, rl, rb, acc);
      #1;
      start = 0; abort = 0; s_valid = 0; rel = 0;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'd0, 0, 0, a);
   endtask

   task automatic feed(input int n, input int pct, input bit pat);
      int got = 0;
      int budget = n * 30 + 200;
      bit a, v;
      while (got < n) begin
         if (budget == 0) begin
            checks++; errors++;
            $display("FAIL feed_timeout accepted=%0d required=%0d", got, n);
            break;
         end
         budget--;
         v = ($urandom_range(99) < pct);
         cyc(0, 0, v, pat ? 8'(got & 15) : 8'($urandom), 0, 0, a);
         if (a) got++;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_bank"}, wr_bank, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_img_done"}, img_done, 0);
      chk({tag, "_img_bank"}, img_bank, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      int w0, d0;
      model_reset();
      #1 rst_n = 0;
      model_reset();
      cmp_en = 1;
      #1 chk_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      idle(2);

      // Back-to-back frame of 0x00..0x0F into bank 0.
      cyc(1, 0, 0, 8'd0, 0, 0, a);
      w0 = n_wr;
      feed(PIX, 100, 1);
      chk("t1_last_wr_en", wr_en, 1);
      chk("t1_last_addr", wr_addr, 783);
      chk("t1_last_data", wr_data, 8'h0F);
      chk("t1_done", img_done, 1);
      chk("t1_done_bank", img_bank, 0);
      chk("t1_ready_bank1", s_ready, 1);
      idle(1);
      chk("t1_write_count", n_wr - w0, PIX);

      // Second frame fills bank 1; no bank left, so the loader stalls.
      feed(PIX, 100, 0);
      chk("t2_done", img_done, 1);
      chk("t2_done_bank", img_bank, 1);
      chk("t2_stall_ready", s_ready, 0);
      chk("t2_stall_busy", busy, 1);
      cyc(0, 0, 0, 8'd0, 1, 0, a);
      chk("t2_ready_plus1", s_ready, 0);
      idle(1);
      chk("t2_ready_plus2", s_ready, 1);
      w0 = n_wr;
      feed(1, 100, 0);
      chk("t2_first_bank", wr_bank, 0);
      chk("t2_first_addr", wr_addr, 0);

      // Remainder of bank 0 with ~50% valid gaps.
      feed(PIX - 1, 50, 0);
      idle(1);
      chk("t3_gap_write_count", n_wr - w0, PIX);

      // Last pixel of bank 0 coincides with release of bank 1.
      cyc(0, 0, 0, 8'd0, 1, 1, a);
      idle(2);
      feed(PIX, 70, 0);
      cyc(0, 0, 0, 8'd0, 1, 0, a);
      idle(2);
      feed(PIX - 1, 100, 0);
      cyc(0, 0, 1, 8'($urandom), 1, 1, a);
      chk("t4_done", img_done, 1);
      chk("t4_done_bank", img_bank, 0);
      chk("t4_no_stall_ready", s_ready, 1);
      feed(1, 100, 0);
      chk("t4_next_bank", wr_bank, 1);
      chk("t4_next_addr", wr_addr, 0);

      // Abort after 300 pixels, then restart into the same bank.
      feed(299, 100, 0);
      d0 = n_done;
      cyc(0, 1, 0, 8'd0, 0, 0, a);
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_ready", s_ready, 0);
      idle(3);
      chk("t5_abort_no_done", n_done - d0, 0);
      cyc(1, 0, 0, 8'd0, 0, 0, a);
      feed(1, 100, 0);
      chk("t5_restart_bank", wr_bank, 1);
      chk("t5_restart_addr", wr_addr, 0);
      feed(PIX - 1, 80, 0);
      chk("t5_done_bank", img_bank, 1);

      // Random control traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(99) < 5, $urandom_range(99) < 1, $urandom_range(99) < 60,
             8'($urandom), $urandom_range(99) < 4, 1'($urandom_range(1)), a);
      end

      // Asynchronous reset mid-frame.
      cyc(0, 0, 0, 8'd0, 1, 0, a);
      cyc(0, 0, 0, 8'd0, 1, 1, a);
      cyc(0, 1, 0, 8'd0, 0, 0, a);
      cyc(1, 0, 0, 8'd0, 0, 0, a);
      feed(500, 100, 0);
      #2 rst_n = 0;
      model_reset();
      #1 chk_zero("async_rst");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1;
      idle(3);
      chk("post_rst_ready", s_ready, 0);
      chk("post_rst_busy", busy, 0);
      cyc(1, 0, 0, 8'd0, 0, 0, a);
      feed(PIX, 90, 0);
      chk("post_rst_done", img_done, 1);
      chk("post_rst_bank", img_bank, 0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter PIXELS, default 784, pixels per image (one 28x28 frame).
REQ-002 Parameter ADDR_W, default 10, pixel address width; SHALL satisfy 2^ADDR_W >= PIXELS.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; arms loading from IDLE; ignored in other states.
REQ-006 abort  input  1  one-cycle pulse; discards the image in progress.
REQ-007 s_valid  input  1  upstream byte valid.
REQ-008 s_data  input  8  upstream pixel byte, signed 8-bit, raster order.
REQ-009 s_ready  output  1  loader accepts s_data this cycle.
REQ-010 wr_en  output  1  image RAM write strobe.
REQ-011 wr_bank  output  1  image RAM bank select for the write.
REQ-012 wr_addr  output  ADDR_W  image RAM write address.
REQ-013 wr_data  output  8  image RAM write data.
REQ-014 img_done  output  1  one-cycle pulse: a bank now holds a complete image.
REQ-015 img_bank  output  1  bank completed, valid with img_done.
REQ-016 release  input  1  one-cycle pulse: consumer has finished with bank release_bank.
REQ-017 release_bank  input  1  bank being released.
REQ-018 busy  output  1  state is not IDLE.

Function
REQ-019 Internal state: FSM {IDLE, FILL, STALL}, pixel counter cnt (0..PIXELS-1), fill bank fb, full flags full[1:0].
REQ-020 Handshake: transfer occurs in cycles where s_valid and s_ready are both 1; s_data is not sampled otherwise.
REQ-021 s_ready SHALL be 1 exactly when state is FILL and full[fb] is 0; it is decoded from registers only, with no combinational path from s_valid.
REQ-022 IDLE: s_ready 0. start moves to FILL with cnt 0; fb is retained.
REQ-023 Each transfer in FILL produces, on the next cycle: wr_en 1, wr_addr = cnt, wr_bank = fb, wr_data = s_data. Latency is exactly 1 cycle; wr_en is 0 in cycles following a non-transfer.
REQ-024 A transfer with cnt < PIXELS-1 increments cnt.
REQ-025 A transfer with cnt = PIXELS-1 (the last pixel) SHALL do the following, with effects visible on the next cycle: set full[fb]; pulse img_done with img_bank = the old fb, coincident with the final wr_en; set cnt to 0; toggle fb.
REQ-026 After the last-pixel transfer, the next state is STALL if full of the new fb is 1, else FILL; loading continues without a further start.
REQ-027 STALL: s_ready 0; move to FILL in the cycle after full[fb] clears.
REQ-028 release: clears full[release_bank]; releasing a bank whose flag is already 0 has no effect.
REQ-029 Release and last-pixel transfer in the same cycle: both take effect; release of the other bank during that cycle SHALL prevent STALL (next state FILL).
REQ-030 abort in FILL or STALL: next state IDLE, cnt 0, full[fb] not set, no img_done; pixels already written stay in RAM but are not flagged.
REQ-031 A transfer in the same cycle as abort SHALL still produce its wr_en write next cycle, then stop.
REQ-032 abort in IDLE is ignored. start coincident with abort: abort wins.
REQ-033 full flags persist across abort and start; only release or reset clears them.

Reset
REQ-034 rst low SHALL immediately force: state IDLE, cnt 0, fb 0, full 2'b00, wr_en 0, wr_bank 0, wr_addr 0, wr_data 0, img_done 0, img_bank 0, busy 0, s_ready 0.
REQ-035 Reset mid-image discards all progress; after rst rises, no write or img_done occurs until a new start.

Verification
REQ-036 Start, then 784 back-to-back bytes 0x00..0x0F repeating -> writes to bank 0, addr 0..783, each 1 cycle after its transfer; img_done=1 and img_bank=0 with the addr 783 write; full=2'b01; s_ready stays 1 for bank 1.
REQ-037 Fill both banks with no release -> after the second img_done (img_bank=1), state STALL and s_ready=0; release with release_bank=0 -> s_ready=1 two cycles later; next write is bank 0, addr 0.
REQ-038 Random s_valid gaps (~50%) -> exactly 784 wr_en pulses per image, addresses contiguous, data equal to accepted bytes in order.
REQ-039 abort after 300 pixels -> IDLE, no img_done, full unchanged; start then 784 bytes -> writes begin at addr 0 in the same bank.
REQ-040 rst asserted asynchronously at pixel 500 (between clock edges) -> all outputs zero immediately; s_ready=0 until start.
REQ-041 Last pixel of bank 0 and release of bank 1 in the same cycle -> no STALL, s_ready=1 on the next cycle, filling bank 1.
